uart_rx: RTL
============

UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter CLKS_PER_BIT, default 16: clk cycles per UART bit; even, minimum 8.
REQ-002 Parameter PARITY_ODD, default 0: 0 selects even parity, 1 selects odd parity.
REQ-003 clk  input  1  single clock; all logic SHALL be on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 rx  input  1  asynchronous serial line; idle high; 0 is the start bit.
REQ-006 data_out  output  8  received data byte, LSB received first.
REQ-007 o_valid  output  1  one-cycle pulse; data_out and the error flags are valid in that cycle.
REQ-008 parity_err  output  1  parity mismatch for the frame, qualified by o_valid.
REQ-009 framing_err  output  1  stop bit sampled low, qualified by o_valid.
REQ-010 o_busy  output  1  high whenever the FSM is not in IDLE.

Function
REQ-011 rx SHALL pass through a 2-flop synchronizer before any use; the synchronized value is rx_s.
REQ-012 Frame format: start(0), d0..d7, parity, stop(1); 11 bit periods in total.
REQ-013 FSM states SHALL be IDLE, START, DATA, PARITY, STOP and BREAK.
- IDLE -> START when rx_s = 0; bit counter is cleared on this transition.
REQ-014 START samples at count CLKS_PER_BIT/2-1.
- rx_s = 1: glitch; SHALL return to IDLE with no o_valid.
- rx_s = 0: -> DATA.
REQ-015 DATA, PARITY and STOP SHALL each sample once per CLKS_PER_BIT cycles, aligned to the bit centre.
REQ-016 DATA SHALL right-shift each sample into an 8-bit register, with the sample entering at bit 7.
- After 8 samples: -> PARITY.
REQ-017 PARITY: parity_err = (XOR(d0..d7) XOR sample) != PARITY_ODD; then -> STOP.
REQ-018 STOP SHALL do all of the following in the cycle after the stop sample:
- update data_out;
- pulse o_valid for exactly one cycle;
- set framing_err = ~sample.
REQ-019 After the stop sample:
- stop sample = 1: -> IDLE.
- stop sample = 0: -> BREAK.
- BREAK -> IDLE only once rx_s = 1.
- A held-low line SHALL produce exactly one o_valid.
REQ-020 parity_err and framing_err SHALL hold until the next o_valid; data_out SHALL hold until the next o_valid.
REQ-021 Latency: o_valid SHALL assert exactly 3 + CLKS_PER_BIT/2 + 10*CLKS_PER_BIT cycles after the first clk edge at which rx is 0.
- With the default CLKS_PER_BIT = 16 this is 171 cycles.
REQ-022 A new frame SHALL be accepted when rx_s falls in the cycle immediately after the return to IDLE.
- Back-to-back frames with a one-bit stop SHALL be received without loss.
REQ-023 rx changes outside the sample points SHALL have no effect (single-sample mode).
REQ-024 The bit counter SHALL be $clog2(CLKS_PER_BIT) bits wide and SHALL wrap to 0 at CLKS_PER_BIT-1.

Reset
REQ-025 While reset is high at a clock edge:
- state = IDLE; counters = 0; both synchronizer flops = 1;
- data_out = 8'h00; o_valid = 0; parity_err = 0; framing_err = 0; o_busy = 0.
REQ-026 Reset asserted mid-frame SHALL abort the frame with no o_valid.
- Reception SHALL resume only on a falling edge of rx_s after reset is released.

Configuration
REQ-027 Macro UART_RX_MAJORITY_EN.
- Defined: each bit value is the majority of rx_s at counts mid-1, mid and mid+1; the decision is taken at mid+1, and REQ-021 latency grows by 1 cycle.
- Undefined: single sample at mid.
- The start-bit glitch check (REQ-014) SHALL use the same rule.

Structure
REQ-028 Package uart_pkg SHALL hold:
- the FSM state enum;
- DATA_BITS = 8;
- FRAME_BITS = 11;
- the parity-select constants shared with the TX path.
REQ-029 The synchronizer SHALL be a sub-module named sync_2ff, reset-value parameterised (1 here).

Verification (CLKS_PER_BIT = 16)
REQ-030 Frame 8'hA5 with even parity bit 0 and stop 1 -> one o_valid, data_out = 8'hA5, parity_err = 0, framing_err = 0, o_valid at cycle 171 (172 with MAJORITY_EN).
REQ-031 Frame 8'h3C with parity bit forced to 1 -> data_out = 8'h3C, parity_err = 1, framing_err = 0.
REQ-032 rx low for 5 cycles then high -> no o_valid; o_busy high for at most 11 cycles, then low.
REQ-033 Frame 8'hFF with stop bit 0, then rx held low for 100 bit times -> exactly one o_valid with framing_err = 1; the next frame 8'h01 is received correctly.
REQ-034 Two back-to-back frames 8'h55 then 8'hAA -> two o_valid pulses 176 cycles apart, data in that order.
REQ-035 Reset pulsed at cycle 80 of a frame -> no o_valid; all outputs at reset values; the following frame 8'h0F is received correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM states, frame geometry, parity select and bit helpers.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4,
    BREAK  = 3'd5
  } uart_state_e;

  localparam int DATA_BITS  = 8;
  localparam int FRAME_BITS = 11;

  // Parity select values, common to the TX and RX paths
  localparam logic PARITY_SEL_EVEN = 1'b0;
  localparam logic PARITY_SEL_ODD  = 1'b1;

  function automatic logic parity_of(input logic [DATA_BITS-1:0] d);
    return ^d;
  endfunction

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous bit; reset value is a parameter.
module sync_2ff #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_meta <= RESET_VAL;
      r_sync <= RESET_VAL;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/uart_rx.sv
// UART receiver: start, 8 data bits LSB first, parity (even/odd via PARITY_ODD), stop.
// Define UART_RX_MAJORITY_EN to decide each bit by a 3-sample majority around the bit centre.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY_ODD   = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  output logic [7:0] data_out,
  output logic       o_valid,
  output logic       parity_err,
  output logic       framing_err,
  output logic       o_busy
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int IDX_W = $clog2(DATA_BITS);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);
`ifdef UART_RX_MAJORITY_EN
  localparam logic [CNT_W-1:0] START_CNT = CNT_W'(CLKS_PER_BIT / 2);
`else
  localparam logic [CNT_W-1:0] START_CNT = CNT_W'(CLKS_PER_BIT / 2 - 1);
`endif
  localparam logic PAR_SEL = (PARITY_ODD != 0) ? PARITY_SEL_ODD : PARITY_SEL_EVEN;

  logic                 w_rx_s;
  logic                 w_sample;
  uart_state_e          r_state;
  logic [CNT_W-1:0]     r_cnt;
  logic [IDX_W-1:0]     r_bit_idx;
  logic [DATA_BITS-1:0] r_shift;
  logic                 r_par_err;
  logic                 r_stop;
  logic                 r_done;
  logic [1:0]           r_settle;
  logic                 r_armed;
  logic [7:0]           r_data_out;
  logic                 r_valid;
  logic                 r_parity_err;
  logic                 r_framing_err;
  logic                 r_busy;

  sync_2ff #(.RESET_VAL(1'b1)) u_sync (
    .clk   (clk),
    .reset (reset),
    .i_d   (rx),
    .o_q   (w_rx_s)
  );

`ifdef UART_RX_MAJORITY_EN
  logic [1:0] r_hist;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_hist <= 2'b11;
    end else begin
      r_hist <= {r_hist[0], w_rx_s};
    end
  end

  assign w_sample = maj3(r_hist[1], r_hist[0], w_rx_s);
`else
  assign w_sample = w_rx_s;
`endif

  // r_armed stays low after reset until the line is seen idle, so a reset mid-frame
  // cannot restart reception on a data bit that happens to be low.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= IDLE;
      r_cnt         <= {CNT_W{1'b0}};
      r_bit_idx     <= {IDX_W{1'b0}};
      r_shift       <= {DATA_BITS{1'b0}};
      r_par_err     <= 1'b0;
      r_stop        <= 1'b1;
      r_done        <= 1'b0;
      r_settle      <= 2'b00;
      r_armed       <= 1'b0;
      r_data_out    <= 8'h00;
      r_valid       <= 1'b0;
      r_parity_err  <= 1'b0;
      r_framing_err <= 1'b0;
      r_busy        <= 1'b0;
    end else begin
      r_done   <= 1'b0;
      r_valid  <= r_done;
      r_settle <= {r_settle[0], 1'b1};
      if (r_settle[1] && w_rx_s) begin
        r_armed <= 1'b1;
      end
      if (r_done) begin
        r_data_out    <= r_shift;
        r_parity_err  <= r_par_err;
        r_framing_err <= ~r_stop;
      end
      case (r_state)
        IDLE: begin
          r_cnt     <= {CNT_W{1'b0}};
          r_bit_idx <= {IDX_W{1'b0}};
          if (r_armed && !w_rx_s) begin
            r_state <= START;
            r_busy  <= 1'b1;
          end
        end
        START: begin
          if (r_cnt == START_CNT) begin
            r_cnt <= {CNT_W{1'b0}};
            if (w_sample) begin
              r_state <= IDLE;
              r_busy  <= 1'b0;
            end else begin
              r_state <= DATA;
            end
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        DATA: begin
          if (r_cnt == LAST_CNT) begin
            r_cnt     <= {CNT_W{1'b0}};
            r_shift   <= {w_sample, r_shift[DATA_BITS-1:1]};
            r_bit_idx <= r_bit_idx + IDX_W'(1);
            if (r_bit_idx == IDX_W'(DATA_BITS - 1)) begin
              r_state <= PARITY;
            end
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        PARITY: begin
          if (r_cnt == LAST_CNT) begin
            r_cnt     <= {CNT_W{1'b0}};
            r_par_err <= (parity_of(r_shift) ^ w_sample) != PAR_SEL;
            r_state   <= STOP;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        STOP: begin
          if (r_cnt == LAST_CNT) begin
            r_cnt  <= {CNT_W{1'b0}};
            r_stop <= w_sample;
            r_done <= 1'b1;
            if (w_sample) begin
              r_state <= IDLE;
              r_busy  <= 1'b0;
            end else begin
              r_state <= BREAK;
            end
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        BREAK: begin
          if (w_rx_s) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign data_out    = r_data_out;
  assign o_valid     = r_valid;
  assign parity_err  = r_parity_err;
  assign framing_err = r_framing_err;
  assign o_busy      = r_busy;

endmodule
